// File: rtl/event_header_writer_if.sv
// FIFO-side bus of the event header writer: write data/enable out, free-slot count back in.
interface event_header_writer_if #(
  parameter int FREE_W = 10
);
  logic [15:0]       FIFO_DIN;
  logic              FIFO_WREN;
  logic [FREE_W-1:0] FIFO_FREE;

  modport master (output FIFO_DIN, output FIFO_WREN, input FIFO_FREE);
  modport slave  (input FIFO_DIN, input FIFO_WREN, output FIFO_FREE);
endinterface

// File: rtl/event_header_writer.sv
// DRS event-header generator: snapshots counters on START, waits for FIFO space, writes HDR_WORDS words.
// Define HDR_CHECKSUM_EN to replace the last header word with the XOR of all preceding emitted words.
//
// state      | meaning
// S_IDLE     | waiting for START_CODE; snapshot taken on the START edge
// S_WAIT     | waiting until FIFO_FREE >= HDR_WORDS, counting stall cycles
// S_WRITE    | one word per cycle; ptr == HDR_WORDS means the last word has gone out
// S_DONE     | header complete, holding DONE until RELEASE_CODE
module event_header_writer #(
  parameter int          N_CNT        = 5,
  parameter int          HDR_WORDS    = 16,
  parameter int          FREE_W       = 10,
  parameter logic [3:0]  START_CODE   = 4'd5,
  parameter logic [3:0]  RELEASE_CODE = 4'd6,
  parameter logic [15:0] EVT_HDR      = 16'hAAAA,
  parameter logic [15:0] PAD_WORD     = 16'hDDDD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            STATE_COM,
  input  logic [32*N_CNT-1:0]   CNT_IN,
  input  logic [15:0]           PPS_COUNTER,
  input  logic                  BYTE_SWAP,
  event_header_writer_if.master fifo,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           STALL_CNT
);

  localparam int               PTR_W    = $clog2(HDR_WORDS + 1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(HDR_WORDS);
  localparam logic [FREE_W:0]  HDR_LEN  = HDR_WORDS[FREE_W:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [32*N_CNT-1:0]  cnt_snap;
  logic [15:0]          pps_snap;
  logic                 swap_snap;
  logic [15:0]          word_raw;
  logic                 is_data;
  logic [15:0]          word_sel;
  logic [15:0]          word_out;
  logic                 space_ok;

  assign space_ok = {1'b0, fifo.FIFO_FREE} >= HDR_LEN;

  // Markers and padding are never byte-swapped; only PPS and counter halves are.
  always_comb begin
    word_raw = PAD_WORD;
    is_data  = 1'b0;
    if (ptr == '0) begin
      word_raw = EVT_HDR;
    end else if (ptr == PTR_W'(1)) begin
      word_raw = pps_snap;
      is_data  = 1'b1;
    end
    for (int i = 0; i < N_CNT; i++) begin
      if (ptr == PTR_W'(2 + 2*i)) begin
        word_raw = cnt_snap[32*i +: 16];
        is_data  = 1'b1;
      end
      if (ptr == PTR_W'(3 + 2*i)) begin
        word_raw = cnt_snap[32*i+16 +: 16];
        is_data  = 1'b1;
      end
    end
    word_sel = (is_data && swap_snap) ? {word_raw[7:0], word_raw[15:8]} : word_raw;
  end

`ifdef HDR_CHECKSUM_EN
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(HDR_WORDS - 1);
  logic [15:0] csum;

  assign word_out = (ptr == LAST_PTR) ? csum : word_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum <= '0;
    end else if (state == S_IDLE) begin
      csum <= '0;
    end else if (state == S_WRITE && ptr != END_PTR) begin
      csum <= csum ^ word_out;
    end
  end
`else
  assign word_out = word_sel;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cnt_snap       <= '0;
      pps_snap       <= '0;
      swap_snap      <= 1'b0;
      fifo.FIFO_DIN  <= '0;
      fifo.FIFO_WREN <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      STALL_CNT      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (STATE_COM == START_CODE) begin
            cnt_snap  <= CNT_IN;
            pps_snap  <= PPS_COUNTER;
            swap_snap <= BYTE_SWAP;
            STALL_CNT <= '0;
            ptr       <= '0;
            BUSY      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (space_ok) begin
            state <= S_WRITE;
          end else if (STALL_CNT != 16'hFFFF) begin
            STALL_CNT <= STALL_CNT + 16'd1;
          end
        end
        S_WRITE: begin
          if (ptr == END_PTR) begin
            fifo.FIFO_WREN <= 1'b0;
            fifo.FIFO_DIN  <= '0;
            BUSY           <= 1'b0;
            DONE           <= 1'b1;
            state          <= S_DONE;
          end else begin
            fifo.FIFO_WREN <= 1'b1;
            fifo.FIFO_DIN  <= word_out;
            ptr            <= ptr + PTR_W'(1);
          end
        end
        S_DONE: begin
          if (STATE_COM == RELEASE_CODE) begin
            DONE  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
